// File: rtl/ppm_sof_eof_detector.sv
// SOF/EOF framing for the oversampled PPM line; all state advances on clk16 ticks.
// Optional macro PPM_FRAME_TIMEOUT_EN adds a MAX_FRAME tick frame timeout on frame_err.
module ppm_sof_eof_detector #(
  parameter int SOF_GAP   = 5,
  parameter int GAP_TOL   = 0,
  parameter int EOF_IDLE  = 32,
  parameter int OUT_DLY   = 2,
  parameter int CNT_W     = 6,
  parameter int MAX_FRAME = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk16,
  input  logic             Din,
  input  logic             eof_rcv_in,
  output logic             sof_rcv_out,
  output logic             eof_rcv_out,
  output logic             frame_active,
  output logic             sof_err,
  output logic             frame_err,
  output logic [CNT_W-1:0] cnt_sof
);

  localparam logic [CNT_W-1:0] WIN_LO   = CNT_W'(SOF_GAP - GAP_TOL);
  localparam logic [CNT_W-1:0] WIN_HI   = CNT_W'(SOF_GAP + GAP_TOL);
  localparam logic [CNT_W-1:0] WIN_END  = CNT_W'(SOF_GAP + GAP_TOL + 1);
  localparam logic [CNT_W-1:0] IDLE_END = CNT_W'(EOF_IDLE - 1);

  if (GAP_TOL >= SOF_GAP || OUT_DLY < 1 || EOF_IDLE < 1 || MAX_FRAME < 1 ||
      SOF_GAP + GAP_TOL + 1 >= 2**CNT_W || EOF_IDLE >= 2**CNT_W) begin : g_param_check
    $error("ppm_sof_eof_detector: inconsistent parameter set");
  end

  typedef enum logic [1:0] {IDLE, GAP, FRAME} state_t;

  state_t             state;
  logic               din_s;
  logic [CNT_W-1:0]   idle_cnt;
  logic [OUT_DLY-1:0] sof_pipe;
  logic               in_window;
  logic               below_window;
  logic               window_end;
  logic               idle_end;

  assign in_window    = (cnt_sof >= WIN_LO) && (cnt_sof <= WIN_HI);
  assign below_window = (cnt_sof < WIN_LO);
  assign window_end   = (cnt_sof == WIN_END);
  assign idle_end     = !din_s && (idle_cnt == IDLE_END);
  assign sof_rcv_out  = sof_pipe[OUT_DLY-1];

`ifdef PPM_FRAME_TIMEOUT_EN
  localparam int               FRM_W     = $clog2(MAX_FRAME + 1);
  localparam logic [FRM_W-1:0] FRAME_END = FRM_W'(MAX_FRAME - 1);

  logic [FRM_W-1:0] frame_cnt;
  logic             frame_timeout;

  assign frame_timeout = (frame_cnt == FRAME_END);
`else
  assign frame_err = 1'b0;
`endif

  // din_s is the previous tick's inverted line sample, so every decision lags Din by one tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      din_s        <= 1'b0;
      cnt_sof      <= '0;
      idle_cnt     <= '0;
      sof_pipe     <= '0;
      eof_rcv_out  <= 1'b0;
      frame_active <= 1'b0;
      sof_err      <= 1'b0;
`ifdef PPM_FRAME_TIMEOUT_EN
      frame_cnt    <= '0;
      frame_err    <= 1'b0;
`endif
    end else if (clk16) begin
      din_s       <= ~Din;
      sof_err     <= 1'b0;
      eof_rcv_out <= 1'b0;
`ifdef PPM_FRAME_TIMEOUT_EN
      frame_err   <= 1'b0;
`endif
      for (int i = 1; i < OUT_DLY; i++) begin
        sof_pipe[i] <= sof_pipe[i-1];
      end
      sof_pipe[0] <= 1'b0;

      if (eof_rcv_in) begin
        eof_rcv_out  <= (state == FRAME);
        state        <= IDLE;
        cnt_sof      <= '0;
        idle_cnt     <= '0;
        sof_pipe     <= '0;
        frame_active <= 1'b0;
`ifdef PPM_FRAME_TIMEOUT_EN
        frame_cnt    <= '0;
`endif
      end else begin
        unique case (state)
          IDLE: begin
            if (din_s) begin
              state   <= GAP;
              cnt_sof <= CNT_W'(1);
            end
          end
          GAP: begin
            if (din_s && in_window) begin
              state        <= FRAME;
              cnt_sof      <= '0;
              idle_cnt     <= '0;
              frame_active <= 1'b1;
              sof_pipe[0]  <= 1'b1;
`ifdef PPM_FRAME_TIMEOUT_EN
              frame_cnt    <= '0;
`endif
            end else if (din_s && below_window) begin
              cnt_sof <= CNT_W'(1);
            end else if (window_end) begin
              // A low landing on the expiry tick becomes the first pulse of a new window.
              sof_err <= 1'b1;
              if (din_s) begin
                cnt_sof <= CNT_W'(1);
              end else begin
                state   <= IDLE;
                cnt_sof <= '0;
              end
            end else begin
              cnt_sof <= cnt_sof + 1'b1;
            end
          end
          FRAME: begin
            if (idle_end) begin
              eof_rcv_out  <= 1'b1;
              state        <= IDLE;
              idle_cnt     <= '0;
              frame_active <= 1'b0;
`ifdef PPM_FRAME_TIMEOUT_EN
              frame_cnt    <= '0;
            end else if (frame_timeout) begin
              frame_err    <= 1'b1;
              state        <= IDLE;
              idle_cnt     <= '0;
              frame_active <= 1'b0;
              frame_cnt    <= '0;
`endif
            end else begin
              idle_cnt <= din_s ? '0 : idle_cnt + 1'b1;
`ifdef PPM_FRAME_TIMEOUT_EN
              frame_cnt <= frame_cnt + 1'b1;
`endif
            end
          end
          default: begin
            state   <= IDLE;
            cnt_sof <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ppm_sof_eof_detector.sv
// Self-checking bench for ppm_sof_eof_detector: per-tick vector tables with a queued scoreboard.
// Two instances share the inputs: defaults, and GAP_TOL=1 / MAX_FRAME=64.
module tb_ppm_sof_eof_detector;

  localparam int CNT_W = 6;

  typedef struct packed {
    logic             sof;
    logic             eof;
    logic             act;
    logic             serr;
    logic             ferr;
    logic [CNT_W-1:0] cnt;
  } obs_t;

  typedef struct {
    logic din;
    logic eof_in;
    obs_t exp;
  } vec_t;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic clk16  = 1'b0;
  logic din    = 1'b1;
  logic eof_in = 1'b0;

  logic             d_sof, d_eof, d_act, d_serr, d_ferr;
  logic [CNT_W-1:0] d_cnt;
  logic             t_sof, t_eof, t_act, t_serr, t_ferr;
  logic [CNT_W-1:0] t_cnt;
  obs_t             obs_def, obs_tol;

  vec_t rows[$];
  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ppm_sof_eof_detector dut (
    .clk(clk), .rst(rst), .clk16(clk16), .Din(din), .eof_rcv_in(eof_in),
    .sof_rcv_out(d_sof), .eof_rcv_out(d_eof), .frame_active(d_act),
    .sof_err(d_serr), .frame_err(d_ferr), .cnt_sof(d_cnt)
  );

  ppm_sof_eof_detector #(.GAP_TOL(1), .MAX_FRAME(64)) dut_tol (
    .clk(clk), .rst(rst), .clk16(clk16), .Din(din), .eof_rcv_in(eof_in),
    .sof_rcv_out(t_sof), .eof_rcv_out(t_eof), .frame_active(t_act),
    .sof_err(t_serr), .frame_err(t_ferr), .cnt_sof(t_cnt)
  );

  assign obs_def = {d_sof, d_eof, d_act, d_serr, d_ferr, d_cnt};
  assign obs_tol = {t_sof, t_eof, t_act, t_serr, t_ferr, t_cnt};

  function automatic obs_t mk(input logic sof, input logic eof, input logic act,
                              input logic serr, input logic ferr, input int cnt);
    return {sof, eof, act, serr, ferr, CNT_W'(cnt)};
  endfunction

  function automatic void push_row(input logic d, input logic e, input obs_t x);
    rows.push_back('{din: d, eof_in: e, exp: x});
  endfunction

  // One sample tick: drive inputs, pulse clk16 for one clk, then idle two clks so held outputs are exercised.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    din    = v.din;
    eof_in = v.eof_in;
    clk16  = 1'b1;
    exp_q.push_back(v.exp);
    @(negedge clk);
    clk16 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic checkOutput(input bit use_tol, input string name, input int t);
    obs_t got, want;
    got = use_tol ? obs_tol : obs_def;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s tick %0d: no expected entry queued", name, t);
      return;
    end
    want = exp_q.pop_front();
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s tick %0d: got sof=%0b eof=%0b act=%0b serr=%0b ferr=%0b cnt=%0d, expected sof=%0b eof=%0b act=%0b serr=%0b ferr=%0b cnt=%0d",
               name, t, got.sof, got.eof, got.act, got.serr, got.ferr, got.cnt,
               want.sof, want.eof, want.act, want.serr, want.ferr, want.cnt);
    end
  endtask

  task automatic run_rows(input bit use_tol, input string name);
    for (int i = 0; i < rows.size(); i++) begin
      applyStimulus(rows[i]);
      checkOutput(use_tol, name, i);
    end
    rows.delete();
  endtask

  task automatic check_zero(input string name);
    checks += 2;
    if (obs_def !== '0) begin
      errors++;
      $display("[TB] FAIL %s default: got %b, expected all zero", name, obs_def);
    end
    if (obs_tol !== '0) begin
      errors++;
      $display("[TB] FAIL %s tol: got %b, expected all zero", name, obs_tol);
    end
  endtask

  // Outputs must clear within 2 ns of rst rising, before any clk edge can act.
  task automatic reset_dut();
    @(negedge clk);
    rst    = 1'b1;
    clk16  = 1'b0;
    din    = 1'b1;
    eof_in = 1'b0;
    #2;
    check_zero("reset_async");
    repeat (2) @(negedge clk);
    check_zero("reset_hold");
    rst = 1'b0;
  endtask

  task automatic frame_idle_eof(input bit ext48, input string name);
    for (int t = 0; t < 50; t++)
      push_row(!(t == 10 || t == 15), ext48 && t == 48,
               mk(t == 17, t == 48, t >= 16 && t < 48, 1'b0, 1'b0,
                  (t >= 11 && t <= 15) ? t - 10 : 0));
    run_rows(1'b0, name);
  endtask

  initial begin
    reset_dut();

    // Pulse at tick 10 opens a window; reset lands while the window is counting.
    for (int t = 0; t < 14; t++)
      push_row(t != 10, 1'b0, mk(0, 0, 0, 0, 0, (t >= 11) ? t - 10 : 0));
    run_rows(1'b0, "gap_before_reset");
    reset_dut();

    frame_idle_eof(1'b0, "sof_then_idle_eof");
    reset_dut();

    frame_idle_eof(1'b1, "idle_eof_with_ext");
    reset_dut();

    // Second low two ticks after the first restarts the window without error.
    for (int t = 0; t < 15; t++) begin
      int c;
      case (t)
        11: c = 1; 12: c = 2; 13: c = 1; 14: c = 2;
        default: c = 0;
      endcase
      push_row(!(t == 10 || t == 12), 1'b0, mk(0, 0, 0, 0, 0, c));
    end
    run_rows(1'b0, "early_restart");
    reset_dut();

    // Gap 6 with zero tolerance: error on expiry, and the expiry-tick low reopens the window.
    for (int t = 0; t < 20; t++) begin
      int c;
      if (t >= 11 && t <= 16) c = t - 10;
      else if (t >= 17) c = t - 16;
      else c = 0;
      push_row(!(t == 10 || t == 16), 1'b0, mk(0, 0, 0, t == 17, 0, c));
    end
    run_rows(1'b0, "late_err_restart");
    reset_dut();

    // Tolerance 1: gap 6 accepted, then external EOF mid-frame.
    for (int t = 0; t < 27; t++)
      push_row(!(t == 10 || t == 16), t == 25,
               mk(t == 18, t == 25, t >= 17 && t < 25, 0, 0, (t >= 11 && t <= 16) ? t - 10 : 0));
    run_rows(1'b1, "tol_gap6_ext_eof");
    reset_dut();

    // Tolerance 1: gap 8 misses the window, error with return to IDLE, then the late low restarts GAP.
    for (int t = 0; t < 22; t++) begin
      int c;
      if (t >= 11 && t <= 17) c = t - 10;
      else if (t >= 19) c = t - 18;
      else c = 0;
      push_row(!(t == 10 || t == 18), 1'b0, mk(0, 0, 0, t == 18, 0, c));
    end
    run_rows(1'b1, "tol_gap8_err");
    reset_dut();

    // External EOF on the confirmation tick suppresses both SOF and EOF.
    for (int t = 0; t < 21; t++)
      push_row(!(t == 10 || t == 15), t == 16,
               mk(0, 0, 0, 0, 0, (t >= 11 && t <= 15) ? t - 10 : 0));
    run_rows(1'b0, "ext_eof_on_confirm");
    reset_dut();

    // Long frame with a low every 4th tick: no idle EOF, lows inside FRAME leave cnt_sof at 0.
    for (int t = 0; t < 82; t++) begin
      logic d;
      obs_t x;
      d = !(t == 10 || t == 15 || (t >= 20 && t % 4 == 0));
`ifdef PPM_FRAME_TIMEOUT_EN
      x = mk(t == 17, 0, t >= 16 && t < 80, 0, t == 80,
             (t >= 11 && t <= 15) ? t - 10 : (t == 81 ? 1 : 0));
`else
      x = mk(t == 17, 0, t >= 16, 0, 0, (t >= 11 && t <= 15) ? t - 10 : 0);
`endif
      push_row(d, 1'b0, x);
    end
    run_rows(1'b1, "frame_timeout");
    reset_dut();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
